// File: rtl/mips_pkg.sv
// Shared constants for the MIPS fetch path: word width, reset vector and the nop encoding.
package mips_pkg;
  localparam int          WORD_W       = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP          = 32'h0000_0000;
  localparam logic [31:0] LINK_OFS     = 32'd8;
endpackage

// File: rtl/im_rom.sv
// Instruction ROM: word-addressed, asynchronous read; contents are supplied by the environment.
module im_rom
  import mips_pkg::*;
#(
  parameter int IM_DEPTH = 1024,
  parameter     IM_FILE  = "code.txt"
) (
  input  logic [$clog2(IM_DEPTH)-1:0] addr,
  output logic [WORD_W-1:0]           data
);

  logic [WORD_W-1:0] r_mem [IM_DEPTH];

  assign data = r_mem[addr];

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: architectural PC register, instruction ROM lookup with range/alignment check,
// and the IF/ID pipeline register with a fetch counter.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          IM_DEPTH = 1024,
  parameter              IM_FILE  = "code.txt"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] NPC,
  input  logic        stall,
  output logic [31:0] PC_F,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC8_D,
  output logic        ferr_D,
  output logic [31:0] fetch_cnt
);

  localparam int          AW       = $clog2(IM_DEPTH);
  localparam logic [31:0] IM_BYTES = 32'(4 * IM_DEPTH);

  logic [31:0]   r_pc;
  logic [31:0]   r_instr_d;
  logic [31:0]   r_pc_d;
  logic [31:0]   r_pc8_d;
  logic          r_ferr_d;
  logic [31:0]   r_cnt;

  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rom_data;
  logic          w_ferr_f;

  // Offset is only meaningful when PC_F >= RESET_PC; otherwise the fault flag masks it.
  assign w_off    = r_pc - RESET_PC;
  assign w_idx    = w_off[AW+1:2];
  assign w_ferr_f = (|r_pc[1:0]) | (r_pc < RESET_PC) | (w_off >= IM_BYTES);

  im_rom #(
    .IM_DEPTH (IM_DEPTH),
    .IM_FILE  (IM_FILE)
  ) u_rom (
    .addr (w_idx),
    .data (w_rom_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc      <= RESET_PC;
      r_instr_d <= NOP;
      r_pc_d    <= RESET_PC;
      r_pc8_d   <= RESET_PC + LINK_OFS;
      r_ferr_d  <= 1'b0;
      r_cnt     <= '0;
    end else if (!stall) begin
      r_pc      <= NPC;
      r_instr_d <= w_ferr_f ? NOP : w_rom_data;
      r_pc_d    <= r_pc;
      r_pc8_d   <= r_pc + LINK_OFS;
      r_ferr_d  <= w_ferr_f;
      r_cnt     <= r_cnt + 32'd1;
    end
  end

  assign PC_F      = r_pc;
  assign Instr_D   = r_instr_d;
  assign PC_D      = r_pc_d;
  assign PC8_D     = r_pc8_d;
  assign ferr_D    = r_ferr_d;
  assign fetch_cnt = r_cnt;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized traffic
// against a behavioural model of the fetch stage.
module tb_pc_fetch_unit;

  localparam logic [31:0] RP    = 32'h0000_3000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] NPC;
  logic        stall;
  logic [31:0] PC_F, Instr_D, PC_D, PC8_D, fetch_cnt;
  logic        ferr_D;

  logic [31:0] rom [DEPTH];

  logic [31:0] m_pc, m_instr, m_pcd, m_pc8, m_cnt;
  logic        m_ferr;

  int n_chk  = 0;
  int n_pass = 0;

  pc_fetch_unit #(
    .RESET_PC (RP),
    .IM_DEPTH (DEPTH),
    .IM_FILE  ("")
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .NPC       (NPC),
    .stall     (stall),
    .PC_F      (PC_F),
    .Instr_D   (Instr_D),
    .PC_D      (PC_D),
    .PC8_D     (PC8_D),
    .ferr_D    (ferr_D),
    .fetch_cnt (fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic is_fault(input logic [31:0] pc);
    longint unsigned p;
    p = longint'(pc);
    return (p % 4 != 0) || (p < longint'(RP)) || (p >= longint'(RP) + 4 * DEPTH);
  endfunction

  function automatic logic [31:0] fetch_word(input logic [31:0] pc);
    if (is_fault(pc)) return 32'h0;
    return rom[(pc - RP) / 4];
  endfunction

  // Advance the reference model by one clock edge with the inputs currently driven.
  task automatic model_edge();
    if (!reset) begin
      m_pc = RP; m_instr = 0; m_pcd = RP; m_pc8 = RP + 8; m_ferr = 0; m_cnt = 0;
    end else if (!stall) begin
      m_instr = fetch_word(m_pc);
      m_ferr  = is_fault(m_pc);
      m_pcd   = m_pc;
      m_pc8   = m_pc + 8;
      m_cnt   = m_cnt + 1;
      m_pc    = NPC;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 0; stall = 0; NPC = 32'h4000;
    step(); step();
    n_chk++; if (PC_F !== 32'h3000) $display("FAIL reset_pc_f got=%h exp=%h", PC_F, 32'h3000); else n_pass++;
    n_chk++; if (Instr_D !== 32'h0) $display("FAIL reset_instr got=%h exp=0", Instr_D); else n_pass++;
    n_chk++; if (PC_D !== 32'h3000) $display("FAIL reset_pc_d got=%h exp=3000", PC_D); else n_pass++;
    n_chk++; if (PC8_D !== 32'h3008) $display("FAIL reset_pc8 got=%h exp=3008", PC8_D); else n_pass++;
    n_chk++; if (ferr_D !== 1'b0) $display("FAIL reset_ferr got=%b exp=0", ferr_D); else n_pass++;
    n_chk++; if (fetch_cnt !== 32'h0) $display("FAIL reset_cnt got=%0d exp=0", fetch_cnt); else n_pass++;
  endtask

  task automatic test_sequential();
    reset = 1; stall = 0;
    for (int i = 0; i < 3; i++) begin
      NPC = RP + 4 * (i + 1);
      step();
      n_chk++; if (Instr_D !== rom[i]) $display("FAIL seq_instr[%0d] got=%h exp=%h", i, Instr_D, rom[i]); else n_pass++;
      n_chk++; if (PC_D !== RP + 4 * i) $display("FAIL seq_pc_d[%0d] got=%h exp=%h", i, PC_D, RP + 4 * i); else n_pass++;
    end
    n_chk++; if (PC_F !== 32'h300C) $display("FAIL seq_pc_f got=%h exp=300c", PC_F); else n_pass++;
    n_chk++; if (fetch_cnt !== 32'd3) $display("FAIL seq_cnt got=%0d exp=3", fetch_cnt); else n_pass++;
  endtask

  task automatic test_stall();
    logic [31:0] h_pc, h_ins, h_pcd, h_pc8, h_cnt;
    logic        h_ferr;
    h_pc = m_pc; h_ins = m_instr; h_pcd = m_pcd; h_pc8 = m_pc8; h_cnt = m_cnt; h_ferr = m_ferr;
    stall = 1; NPC = 32'h3100;
    step(); step();
    n_chk++; if (PC_F !== h_pc) $display("FAIL stall_pc_f got=%h exp=%h", PC_F, h_pc); else n_pass++;
    n_chk++; if (Instr_D !== h_ins) $display("FAIL stall_instr got=%h exp=%h", Instr_D, h_ins); else n_pass++;
    n_chk++; if (PC_D !== h_pcd) $display("FAIL stall_pc_d got=%h exp=%h", PC_D, h_pcd); else n_pass++;
    n_chk++; if (PC8_D !== h_pc8) $display("FAIL stall_pc8 got=%h exp=%h", PC8_D, h_pc8); else n_pass++;
    n_chk++; if (ferr_D !== h_ferr) $display("FAIL stall_ferr got=%b exp=%b", ferr_D, h_ferr); else n_pass++;
    n_chk++; if (fetch_cnt !== h_cnt) $display("FAIL stall_cnt got=%0d exp=%0d", fetch_cnt, h_cnt); else n_pass++;
    stall = 0;
    step();
    n_chk++; if (PC_F !== 32'h3100) $display("FAIL stall_release_pc got=%h exp=3100", PC_F); else n_pass++;
  endtask

  task automatic test_misaligned();
    NPC = 32'h3002;
    step();
    n_chk++; if (PC_F !== 32'h3002) $display("FAIL mis_pc_f got=%h exp=3002", PC_F); else n_pass++;
    n_chk++; if (ferr_D !== 1'b0) $display("FAIL mis_early_ferr got=%b exp=0", ferr_D); else n_pass++;
    NPC = 32'h3004;
    step();
    n_chk++; if (Instr_D !== 32'h0) $display("FAIL mis_instr got=%h exp=0", Instr_D); else n_pass++;
    n_chk++; if (ferr_D !== 1'b1) $display("FAIL mis_ferr got=%b exp=1", ferr_D); else n_pass++;
    n_chk++; if (PC_D !== 32'h3002) $display("FAIL mis_pc_d got=%h exp=3002", PC_D); else n_pass++;
  endtask

  task automatic test_out_of_range();
    // Last valid word must fetch cleanly.
    NPC = RP + 4 * DEPTH - 4; step();
    NPC = RP + 4 * DEPTH;     step();
    n_chk++; if (ferr_D !== 1'b0 || Instr_D !== rom[DEPTH-1])
      $display("FAIL oor_last_word got=%h/%b exp=%h/0", Instr_D, ferr_D, rom[DEPTH-1]); else n_pass++;
    NPC = 32'h2FFC; step();
    n_chk++; if (ferr_D !== 1'b1 || Instr_D !== 32'h0)
      $display("FAIL oor_high got=%h/%b exp=0/1", Instr_D, ferr_D); else n_pass++;
    NPC = 32'hFFFF_FFFC; step();
    n_chk++; if (ferr_D !== 1'b1 || Instr_D !== 32'h0 || PC_D !== 32'h2FFC)
      $display("FAIL oor_low got=%h/%b/%h exp=0/1/2ffc", Instr_D, ferr_D, PC_D); else n_pass++;
    NPC = RP; step();
    n_chk++; if (PC8_D !== 32'h0000_0004) $display("FAIL wrap_pc8 got=%h exp=4", PC8_D); else n_pass++;
  endtask

  task automatic test_reset_in_stall();
    NPC = 32'h3100; stall = 0; step();
    stall = 1; reset = 0; NPC = 32'h3200; step();
    n_chk++; if (PC_F !== 32'h3000) $display("FAIL rst_stall_pc got=%h exp=3000", PC_F); else n_pass++;
    n_chk++; if (fetch_cnt !== 32'h0) $display("FAIL rst_stall_cnt got=%0d exp=0", fetch_cnt); else n_pass++;
    reset = 1; stall = 0;
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) >= 4);
      stall = ($urandom_range(0, 99) < 25);
      r = $urandom_range(0, 9);
      if (r < 5)       NPC = m_pc + 4;
      else if (r < 7)  NPC = RP + 4 * $urandom_range(0, DEPTH - 1);
      else if (r == 7) NPC = RP + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
      else if (r == 8) NPC = RP + 4 * DEPTH + 4 * $urandom_range(0, 15);
      else             NPC = $urandom;
      step();
      n_chk++;
      if (PC_F !== m_pc || Instr_D !== m_instr || PC_D !== m_pcd || PC8_D !== m_pc8 ||
          ferr_D !== m_ferr || fetch_cnt !== m_cnt)
        $display("FAIL rand[%0d] got pc=%h ins=%h pcd=%h pc8=%h ferr=%b cnt=%0d exp pc=%h ins=%h pcd=%h pc8=%h ferr=%b cnt=%0d",
                 i, PC_F, Instr_D, PC_D, PC8_D, ferr_D, fetch_cnt,
                 m_pc, m_instr, m_pcd, m_pc8, m_ferr, m_cnt);
      else n_pass++;
    end
  endtask

  initial begin
    reset = 0; stall = 0; NPC = 0;
    m_pc = 0; m_instr = 0; m_pcd = 0; m_pc8 = 0; m_ferr = 0; m_cnt = 0;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      rom[i] = $urandom;
      if (i < 3 && rom[i] == 32'h0) rom[i] = 32'h2408_0001 + i;
      dut.u_rom.r_mem[i] = rom[i];
    end
    test_reset();
    test_sequential();
    test_stall();
    test_misaligned();
    test_out_of_range();
    test_reset_in_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
